// File: rtl/aud_i2s_recorder.sv
//==============================================================================
// Module      : aud_i2s_recorder
// Description : WM8731 ADC capture path. Deserialises one I2S channel per
//               LRCK frame (codec is bus master) and hands each sample, with
//               its SRAM word address, to the SRAM writer over valid/ready.
//               Start / pause / stop are single-cycle key pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module aud_i2s_recorder #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF,
    parameter int                CHANNEL  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_AUD_BCLK,
    input  logic              i_AUD_ADCLRCK,
    input  logic              i_AUD_ADCDAT,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [ADDR_W-1:0] o_len,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_overrun
);

    // Bit counter holds 0 (waiting for the skipped I2S slot) .. DATA_W
    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LR = 3'd1;
    localparam logic [2:0] c_ST_SHIFT   = 3'd2;
    localparam logic [2:0] c_ST_HOLD    = 3'd3;
    localparam logic [2:0] c_ST_PAUSED  = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    // Synchroniser stages and previous-cycle copies for edge detection
    logic r_bclk_meta, r_bclk_sync, r_bclk_prev;
    logic r_lr_meta,   r_lr_sync,   r_lr_prev;
    logic r_dat_meta,  r_dat_sync;

    logic [2:0]        r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-2:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_len;
    logic              r_full;
    logic              r_overrun;
    logic              r_pause_pend;

    logic [2:0]        w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [DATA_W-2:0] w_shift_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_len_nxt;
    logic              w_full_nxt;
    logic              w_ovr_nxt;
    logic              w_pend_nxt;

    logic              w_bclk_rise;
    logic              w_lr_rise;
    logic              w_lr_fall;
    logic              w_lr_edge;
    logic              w_frame_start;
    logic              w_accept;
    logic              w_start_go;
    logic [DATA_W-1:0] w_shift_in;

    assign w_bclk_rise = r_bclk_sync & ~r_bclk_prev;
    assign w_lr_rise   = r_lr_sync & ~r_lr_prev;
    assign w_lr_fall   = ~r_lr_sync & r_lr_prev;
    assign w_lr_edge   = w_lr_rise | w_lr_fall;
    assign w_accept    = r_valid & i_ready;
    // Pause outranks start when both arrive together
    assign w_start_go  = i_start & ~i_pause;
    assign w_shift_in  = {r_shift, r_dat_sync};

    // Frame start is the LRCK edge that enters the captured half
    generate
        if (CHANNEL == 0) begin : g_left
            assign w_frame_start = w_lr_fall;
        end else begin : g_right
            assign w_frame_start = w_lr_rise;
        end
    endgenerate

    // Next-state and datapath update for the capture state machine
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_full_nxt  = r_full;
        w_ovr_nxt   = r_overrun;
        w_pend_nxt  = r_pause_pend;

        // A handshake completes regardless of any simultaneous stop
        if (w_accept) begin
            w_len_nxt = r_len + c_ADDR_ONE;
        end

        if (i_stop) begin
            w_state_nxt = c_ST_IDLE;
            w_valid_nxt = 1'b0;
            w_pend_nxt  = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_start_go) begin
                        w_addr_nxt  = '0;
                        w_len_nxt   = '0;
                        w_full_nxt  = 1'b0;
                        w_ovr_nxt   = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = c_ST_WAIT_LR;
                    end
                end
                c_ST_WAIT_LR: begin
                    if (i_pause) begin
                        w_state_nxt = c_ST_PAUSED;
                    end else if (w_frame_start) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (i_pause) begin
                        w_state_nxt = c_ST_PAUSED;
                        w_cnt_nxt   = '0;
                    end else if (w_lr_edge) begin
                        // Partial sample is lost; restart only on a qualifying edge
                        w_cnt_nxt = '0;
                        if (!w_frame_start) begin
                            w_state_nxt = c_ST_WAIT_LR;
                        end
                    end else if (w_bclk_rise) begin
                        if (r_bit_cnt == '0) begin
                            // I2S: the first rise after the LRCK edge carries no data
                            w_cnt_nxt = c_CNT_ONE;
                        end else begin
                            w_shift_nxt = w_shift_in[DATA_W-2:0];
                            if (r_bit_cnt == c_CNT_LAST) begin
                                w_data_nxt  = w_shift_in;
                                w_valid_nxt = 1'b1;
                                w_cnt_nxt   = '0;
                                w_state_nxt = c_ST_HOLD;
                            end else begin
                                w_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                            end
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (w_frame_start) begin
                        w_ovr_nxt = 1'b1;
                    end
                    if (i_pause) begin
                        w_pend_nxt = 1'b1;
                    end
                    if (w_accept) begin
                        w_valid_nxt = 1'b0;
                        w_pend_nxt  = 1'b0;
                        if (r_addr == MAX_ADDR) begin
                            w_full_nxt  = 1'b1;
                            w_state_nxt = c_ST_DONE;
                        end else begin
                            w_addr_nxt  = r_addr + c_ADDR_ONE;
                            w_state_nxt = (r_pause_pend | i_pause) ? c_ST_PAUSED : c_ST_WAIT_LR;
                        end
                    end
                end
                c_ST_PAUSED: begin
                    if (w_start_go) begin
                        w_state_nxt = c_ST_WAIT_LR;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Input synchronisers and state register; reset ignores the codec lines
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bclk_meta  <= 1'b0;
            r_bclk_sync  <= 1'b0;
            r_bclk_prev  <= 1'b0;
            r_lr_meta    <= 1'b0;
            r_lr_sync    <= 1'b0;
            r_lr_prev    <= 1'b0;
            r_dat_meta   <= 1'b0;
            r_dat_sync   <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_full       <= 1'b0;
            r_overrun    <= 1'b0;
            r_pause_pend <= 1'b0;
        end else begin
            r_bclk_meta  <= i_AUD_BCLK;
            r_bclk_sync  <= r_bclk_meta;
            r_bclk_prev  <= r_bclk_sync;
            r_lr_meta    <= i_AUD_ADCLRCK;
            r_lr_sync    <= r_lr_meta;
            r_lr_prev    <= r_lr_sync;
            r_dat_meta   <= i_AUD_ADCDAT;
            r_dat_sync   <= r_dat_meta;
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_addr       <= w_addr_nxt;
            r_len        <= w_len_nxt;
            r_full       <= w_full_nxt;
            r_overrun    <= w_ovr_nxt;
            r_pause_pend <= w_pend_nxt;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_address = r_addr;
    assign o_len     = r_len;
    assign o_full    = r_full;
    assign o_overrun = r_overrun;
    assign o_busy    = (r_state == c_ST_WAIT_LR) || (r_state == c_ST_SHIFT) ||
                       (r_state == c_ST_HOLD);

endmodule

`default_nettype wire
